// File: rtl/hrange_lanes.sv
// Multi-lane arithmetic range generator: emits base, base+step, ... packed LANES per beat
// over a ready/valid/done handshake, with overflow-safe widened comparisons.
module hrange_lanes #(
    parameter int WIDTH     = 32,
    parameter int LANES     = 2,
    parameter int INCLUSIVE = 0
) (
    input  logic                     _clock,
    input  logic                     _reset,
    input  logic                     _start,
    input  logic signed [WIDTH-1:0]  base,
    input  logic signed [WIDTH-1:0]  limit,
    input  logic signed [WIDTH-1:0]  step,
    input  logic                     _ready,
    output logic                     _valid,
    output logic                     _done,
    output logic [LANES*WIDTH-1:0]   _out,
    output logic [LANES-1:0]         _keep,
    output logic                     _last
);

    // Headroom for cur + LANES*step without wrap-around.
    localparam int AW = WIDTH + $clog2(LANES) + 2;

    typedef enum logic {DONE, RUN} state_t;

    state_t                state;
    logic signed [AW-1:0]  cur;
    logic signed [AW-1:0]  lim_r;
    logic signed [AW-1:0]  step_r;
    logic                  ended;

    logic signed [AW-1:0]  src_cur;
    logic signed [AW-1:0]  src_lim;
    logic signed [AW-1:0]  src_step;
    logic signed [AW-1:0]  lane_v [LANES];
    logic signed [AW-1:0]  next_cur;
    logic [LANES-1:0]      beat_keep;
    logic [LANES*WIDTH-1:0] beat_out;
    logic                  beat_last;

    function automatic logic signed [AW-1:0] ext(input logic signed [WIDTH-1:0] v);
        return {{(AW-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    function automatic logic in_range(input logic signed [AW-1:0] v,
                                      input logic signed [AW-1:0] lim,
                                      input logic signed [AW-1:0] stp);
        if (stp == '0)
            return 1'b0;
        else if (!stp[AW-1])
            return (INCLUSIVE != 0) ? (v <= lim) : (v < lim);
        else
            return (INCLUSIVE != 0) ? (v >= lim) : (v > lim);
    endfunction

    // A start forms its first beat straight from the inputs so it is valid next cycle.
    always_comb begin
        src_cur  = _start ? ext(base)  : cur;
        src_lim  = _start ? ext(limit) : lim_r;
        src_step = _start ? ext(step)  : step_r;
        beat_out = '0;
        lane_v[0]    = src_cur;
        beat_keep[0] = in_range(src_cur, src_lim, src_step);
        for (int k = 1; k < LANES; k++) begin
            lane_v[k]    = lane_v[k-1] + src_step;
            beat_keep[k] = beat_keep[k-1] && in_range(lane_v[k], src_lim, src_step);
        end
        for (int k = 0; k < LANES; k++) begin
            if (beat_keep[k])
                beat_out[k*WIDTH +: WIDTH] = lane_v[k][WIDTH-1:0];
        end
        next_cur  = lane_v[LANES-1] + src_step;
        beat_last = !beat_keep[LANES-1] || !in_range(next_cur, src_lim, src_step);
    end

    always_ff @(posedge _clock) begin
        if (!_reset) begin
            state  <= DONE;
            _valid <= 1'b0;
            _out   <= '0;
            _keep  <= '0;
            _last  <= 1'b0;
            ended  <= 1'b0;
        end else if (_start) begin
            lim_r  <= src_lim;
            step_r <= src_step;
            cur    <= next_cur;
            if (!beat_keep[0]) begin
                state  <= DONE;
                _valid <= 1'b0;
                _out   <= '0;
                _keep  <= '0;
                _last  <= 1'b0;
                ended  <= 1'b0;
            end else begin
                state  <= RUN;
                _valid <= 1'b1;
                _out   <= beat_out;
                _keep  <= beat_keep;
                _last  <= beat_last;
                ended  <= beat_last;
            end
        end else if (state == RUN) begin
            if (_valid && _ready && _last) begin
                state  <= DONE;
                _valid <= 1'b0;
            end else if ((!_valid || _ready) && !ended) begin
                _valid <= 1'b1;
                _out   <= beat_out;
                _keep  <= beat_keep;
                _last  <= beat_last;
                ended  <= beat_last;
                cur    <= next_cur;
            end else if (_valid && _ready) begin
                _valid <= 1'b0;
            end
        end
    end

    assign _done = (state == DONE);

endmodule
